dma_reg_write_decoder: RTL

- Parametrised successor of the DMA register address decoder.
- Decodes CPU I/O writes during the idle cycle (hlda=0) into a one-hot register select and holds the programmed register contents: per-channel base address/count, command, mode, mask and request.
- Multi-byte address/count registers are written through a byte-pointer counter, generalising the single-byte first/last flip-flop.
- Sits between the CPU bus interface and the DMA channel/timing logic.

---
 rtl/dma_dec_pkg.sv | 24 ++
 rtl/dma_strobe_edge.sv | 23 ++
 rtl/dma_reg_write_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dma_dec_pkg.sv
// Shared definitions for the DMA register write decoder: control-region
// offsets and the one-hot register select index helper.
// Optional read-back (macro DMA_REG_READBACK_EN) uses the same definitions.
package dma_dec_pkg;

  // Offsets of the control registers above the channel region
  localparam int OFS_CMD     = 0;
  localparam int OFS_REQ     = 1;
  localparam int OFS_SMASK   = 2;
  localparam int OFS_MODE    = 3;
  localparam int OFS_CLRBP   = 4;
  localparam int OFS_MCLR    = 5;
  localparam int OFS_CLRMASK = 6;
  localparam int OFS_ALLMASK = 7;

  // One-hot select index for an address, or -1 when the address decodes to nothing
  function automatic int oneHotIndex(input int addr, input int chNum);
    if (addr >= 0 && addr < 2 * chNum + 8) begin
      return addr;
    end
    return -1;
  endfunction

endpackage

// File: rtl/dma_strobe_edge.sv
// Registers a bus strobe qualifier and produces a one-cycle pulse on its
// rising edge, so a held strobe is accepted exactly once.
module dma_strobe_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic qual_i,
  output logic pulse_o
);

  logic qual_q;

  // Remember last cycle's qualifier; reset clears it so a still-active strobe re-triggers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_q <= 1'b0;
    end else begin
      qual_q <= qual_i;
    end
  end

  assign pulse_o = qual_i & ~qual_q;

endmodule

// File: rtl/dma_reg_write_decoder.sv
// DMA register write decoder: turns idle-cycle CPU I/O writes into a one-hot
// register select and holds the programmed channel and control registers.
// Multi-byte base registers are filled through a shared wrapping byte pointer.
// Optional read-back port is enabled with macro DMA_REG_READBACK_EN.
module dma_reg_write_decoder
  import dma_dec_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int REG_BYTES = 2,
  parameter int ADDR_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cs_n,
  input  logic                            iow_n,
  input  logic                            hlda,
  input  logic [ADDR_W-1:0]               addr,
  input  logic [7:0]                      db_in,
`ifdef DMA_REG_READBACK_EN
  input  logic                            ior_n,
  output logic [7:0]                      db_out,
  output logic                            db_oe,
`endif
  output logic [2*CH_NUM+7:0]             wr_sel,
  output logic [CH_NUM*REG_BYTES*8-1:0]   base_addr,
  output logic [CH_NUM*REG_BYTES*8-1:0]   base_cnt,
  output logic [7:0]                      command_reg,
  output logic [CH_NUM*6-1:0]             mode_reg,
  output logic [CH_NUM-1:0]               mask_reg,
  output logic [CH_NUM-1:0]               req_reg,
  output logic [$clog2(REG_BYTES)-1:0]    byte_ptr,
  output logic                            mclr_pulse
);

  localparam int SEL_W = 2 * CH_NUM + 8;
  localparam int REG_W = REG_BYTES * 8;
  localparam int BP_W  = $clog2(REG_BYTES);

  logic                             wq;
  logic                             wrPulse;
  int                               addrInt;
  int                               chField;
  logic [CH_NUM-1:0][REG_W-1:0]     baseAddr_q, baseAddr_d;
  logic [CH_NUM-1:0][REG_W-1:0]     baseCnt_q, baseCnt_d;
  logic [7:0]                       command_q, command_d;
  logic [CH_NUM-1:0][5:0]           mode_q, mode_d;
  logic [CH_NUM-1:0]                mask_q, mask_d;
  logic [CH_NUM-1:0]                req_q, req_d;
  logic [BP_W-1:0]                  bytePtr_q, bytePtr_d, bytePtrNext;
  logic [SEL_W-1:0]                 wrSel_q, wrSel_d;
  logic                             mclr_q, mclr_d;

  assign wq = ~cs_n & ~iow_n & ~hlda;

  dma_strobe_edge uWrEdge (
    .clk     (clk),
    .rst_n   (rst_n),
    .qual_i  (wq),
    .pulse_o (wrPulse)
  );

`ifdef DMA_REG_READBACK_EN
  logic       rdQual;
  logic       rdPulse;
  logic [7:0] dbOut_q, dbOut_d;
  logic       dbOe_q;

  assign rdQual = ~cs_n & ~ior_n & ~hlda;

  dma_strobe_edge uRdEdge (
    .clk     (clk),
    .rst_n   (rst_n),
    .qual_i  (rdQual),
    .pulse_o (rdPulse)
  );

  assign db_out = dbOut_q;
  assign db_oe  = dbOe_q;
`endif

  assign bytePtrNext = (bytePtr_q == BP_W'(REG_BYTES - 1)) ? '0 : bytePtr_q + BP_W'(1);

  // Decode an accepted access and compute the next register contents
  always_comb begin
    baseAddr_d = baseAddr_q;
    baseCnt_d  = baseCnt_q;
    command_d  = command_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    req_d      = req_q;
    bytePtr_d  = bytePtr_q;
    wrSel_d    = '0;
    mclr_d     = 1'b0;
    addrInt    = int'(addr);
    chField    = int'(db_in[1:0]);
`ifdef DMA_REG_READBACK_EN
    dbOut_d    = dbOut_q;
`endif
    if (wrPulse) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (oneHotIndex(addrInt, CH_NUM) == i) wrSel_d[i] = 1'b1;
      end
      if (addrInt < 2 * CH_NUM) begin
        for (int c = 0; c < CH_NUM; c++) begin
          for (int b = 0; b < REG_BYTES; b++) begin
            if (addrInt / 2 == c && int'(bytePtr_q) == b) begin
              if (addr[0]) baseCnt_d[c][b*8 +: 8] = db_in;
              else         baseAddr_d[c][b*8 +: 8] = db_in;
            end
          end
        end
        bytePtr_d = bytePtrNext;
      end else begin
        case (addrInt - 2 * CH_NUM)
          OFS_CMD: command_d = db_in;
          OFS_REQ: begin
            for (int c = 0; c < CH_NUM; c++) begin
              if (chField == c) req_d[c] = db_in[2];
            end
          end
          OFS_SMASK: begin
            for (int c = 0; c < CH_NUM; c++) begin
              if (chField == c) mask_d[c] = db_in[2];
            end
          end
          OFS_MODE: begin
            for (int c = 0; c < CH_NUM; c++) begin
              if (chField == c) mode_d[c] = db_in[7:2];
            end
          end
          OFS_CLRBP: bytePtr_d = '0;
          OFS_MCLR: begin
            baseAddr_d = '0;
            baseCnt_d  = '0;
            command_d  = '0;
            mode_d     = '0;
            mask_d     = '1;
            req_d      = '0;
            bytePtr_d  = '0;
            mclr_d     = 1'b1;
          end
          OFS_CLRMASK: mask_d = '0;
          OFS_ALLMASK: mask_d = db_in[CH_NUM-1:0];
          default: ;
        endcase
      end
    end
`ifdef DMA_REG_READBACK_EN
    else if (rdPulse) begin
      if (addrInt < 2 * CH_NUM) begin
        for (int c = 0; c < CH_NUM; c++) begin
          for (int b = 0; b < REG_BYTES; b++) begin
            if (addrInt / 2 == c && int'(bytePtr_q) == b) begin
              if (addr[0]) dbOut_d = baseCnt_q[c][b*8 +: 8];
              else         dbOut_d = baseAddr_q[c][b*8 +: 8];
            end
          end
        end
        bytePtr_d = bytePtrNext;
      end else begin
        dbOut_d = command_q;
      end
    end
`endif
  end

  // Register file, byte pointer and one-cycle select/clear pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baseAddr_q <= '0;
      baseCnt_q  <= '0;
      command_q  <= '0;
      mode_q     <= '0;
      mask_q     <= '1;
      req_q      <= '0;
      bytePtr_q  <= '0;
      wrSel_q    <= '0;
      mclr_q     <= 1'b0;
    end else begin
      baseAddr_q <= baseAddr_d;
      baseCnt_q  <= baseCnt_d;
      command_q  <= command_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      req_q      <= req_d;
      bytePtr_q  <= bytePtr_d;
      wrSel_q    <= wrSel_d;
      mclr_q     <= mclr_d;
    end
  end

`ifdef DMA_REG_READBACK_EN
  // Read data and output enable, both one cycle behind the read qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbOut_q <= '0;
      dbOe_q  <= 1'b0;
    end else begin
      dbOut_q <= dbOut_d;
      dbOe_q  <= rdQual;
    end
  end
`endif

  assign wr_sel      = wrSel_q;
  assign base_addr   = baseAddr_q;
  assign base_cnt    = baseCnt_q;
  assign command_reg = command_q;
  assign mode_reg    = mode_q;
  assign mask_reg    = mask_q;
  assign req_reg     = req_q;
  assign byte_ptr    = bytePtr_q;
  assign mclr_pulse  = mclr_q;

endmodule
